// File: rtl/jtframe_lnbuf_pkg.sv
// Shared types and constants for the ping-pong line buffer controller.
package jtframe_lnbuf_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [7:0] LOST_MAX = 8'hFF;

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == LOST_MAX) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/jtframe_lnbuf_ctrl_if.sv
// Game-side line handshake: the core renders line ln_v on ln_hs and writes it back.
interface jtframe_lnbuf_ctrl_if #(
   parameter int HW = 9,
   parameter int DW = 16
);
   logic [HW-1:0] ln_addr;
   logic [DW-1:0] ln_data;
   logic          ln_we;
   logic          ln_done;
   logic          ln_hs;
   logic [7:0]    ln_v;

   modport master (output ln_addr, ln_data, ln_we, ln_done, input  ln_hs, ln_v);
   modport slave  (input  ln_addr, ln_data, ln_we, ln_done, output ln_hs, ln_v);
endinterface

// File: rtl/jtframe_lnbuf_ram.sv
// One line bank: single write port, single synchronous read port.
module jtframe_lnbuf_ram #(
   parameter int AW = 9,
   parameter int DW = 16
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] q
);
   localparam int DEPTH = 1 << AW;

   logic [DW-1:0] mem [DEPTH];

   // NOTE: the array and read register have no reset so the bank maps onto block RAM.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (re) q <= mem[raddr];
   end
endmodule

// File: rtl/jtframe_lnbuf_ctrl.sv
// Ping-pong line buffer controller. Optional JTFRAME_LFBUF_CLR_EN: front-bank
// pixels are zeroed right after being displayed, so late lines show black.
module jtframe_lnbuf_ctrl
   import jtframe_lnbuf_pkg::*;
#(
   parameter int HW = 9,
   parameter int DW = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  pxl_cen,
   input  logic                  lhbl,
   input  logic                  lvbl,
   input  logic [7:0]            vrender,
   input  logic [HW-1:0]         hdump,
   jtframe_lnbuf_ctrl_if.slave   game,
   output logic [DW-1:0]         ln_pxl,
   output logic [7:0]            st_lost
);
   state_t        state, state_nxt;
   logic          lhbl_l, hb_evt;
   logic          wr_bank;
   logic          swap, req, lost;
   logic          game_we;
   logic          rd_en, rd_vld, rd_blank, rd_bank;
   logic          clr_we;
   logic [HW-1:0] clr_addr;
   logic [DW-1:0] q [2];

   assign hb_evt  = lhbl_l & ~lhbl;
   assign game_we = game.ln_we && (state == FILL);
   assign rd_en   = pxl_cen & lhbl;

   // NOTE: every combinational output gets a default first so no latch is inferred.
   always_comb begin
      state_nxt = state;
      swap      = 1'b0;
      req       = 1'b0;
      lost      = 1'b0;
      case (state)
         IDLE: if (hb_evt && lvbl) begin
            req       = 1'b1;
            state_nxt = FILL;
         end
         FILL: begin
            if (hb_evt)       lost      = 1'b1;
            if (game.ln_done) state_nxt = DONE;
         end
         DONE: if (hb_evt) begin
            swap = 1'b1;
            if (lvbl) begin
               req       = 1'b1;
               state_nxt = FILL;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         lhbl_l     <= 1'b0;
         wr_bank    <= 1'b0;
         game.ln_hs <= 1'b0;
         game.ln_v  <= 8'd0;
         st_lost    <= 8'd0;
      end else begin
         state      <= state_nxt;
         lhbl_l     <= lhbl;
         game.ln_hs <= req;
         if (req)  game.ln_v <= vrender;
         if (swap) wr_bank   <= ~wr_bank;
         if (lost) st_lost   <= sat_inc(st_lost);
      end
   end

   // Two-stage read: RAM register, then output register selected by the bank that was read.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_vld   <= 1'b0;
         rd_blank <= 1'b0;
         rd_bank  <= 1'b0;
         ln_pxl   <= '0;
      end else begin
         rd_vld   <= pxl_cen;
         rd_blank <= ~lhbl;
         rd_bank  <= ~wr_bank;
         if (rd_vld) ln_pxl <= rd_blank ? '0 : q[rd_bank];
      end
   end

`ifdef JTFRAME_LFBUF_CLR_EN
   always_ff @(posedge clk) begin
      if (rd_en) clr_addr <= hdump;
   end
   assign clr_we = rd_vld & ~rd_blank;
`else
   assign clr_we   = 1'b0;
   assign clr_addr = '0;
`endif

   // The back bank only sees game writes, the front bank only clear writes.
   for (genvar b = 0; b < 2; b++) begin : g_bank
      logic back;
      assign back = (wr_bank == 1'(b));

      jtframe_lnbuf_ram #(.AW(HW), .DW(DW)) u_ram (
         .clk   (clk),
         .we    (back ? game_we      : clr_we),
         .waddr (back ? game.ln_addr : clr_addr),
         .wdata (back ? game.ln_data : '0),
         .re    (rd_en),
         .raddr (hdump),
         .q     (q[b])
      );
   end
endmodule
